dallanma_ongorucu: RTL and testbench
====================================

Name: dallanma_ongorucu

Overview:
- Fetch-side branch predictor: the predicting counterpart of the execute-stage branch resolution unit.
- Direct-mapped branch target buffer (BTB) with a 2-bit saturating counter per entry.
- Looked up by fetch with one-cycle registered latency; trained by the resolved outcome and target from execute (JAL/JALR/Bxx).
- Output drives the fetch next-PC mux.

Parameters:
- GIRDI_SAYISI, 16, number of BTB entries; power of two, 2..64.
- IDX_BIT, $clog2(GIRDI_SAYISI), index width. Index = ps[IDX_BIT+1:2]; tag = ps[31:IDX_BIT+2].

Ports:
- clk_g  input  1  clock.
- rstn_g  input  1  reset.
- getir_gecerli_g  input  1  fetch lookup request valid.
- getir_ps_g  input  32  fetch PC to predict.
- bosalt_g  input  1  pipeline flush; kills the in-flight prediction.
- ongoru_gecerli_c  output  1  prediction valid, one cycle after request.
- ongoru_atla_c  output  1  predicted taken.
- ongoru_ps_c  output  32  predicted next PC.
- guncelle_gecerli_g  input  1  training update valid (resolved control-transfer instruction).
- guncelle_ps_g  input  32  PC of the resolved instruction.
- guncelle_atladi_g  input  1  actual outcome: 1 = taken (branch result, or any JAL/JALR).
- guncelle_hedef_g  input  32  actual target PC.
- guncelle_atlama_g  input  1  1 = unconditional (JAL/JALR), 0 = conditional Bxx.

Behaviour:
- Clocking and reset:
  - Single clock, rising edge.
  - Reset is synchronous, active-low (rstn_g = 0 sampled at the clock edge).
  - Reset clears all valid bits and sets ongoru_gecerli_c=0, ongoru_atla_c=0, ongoru_ps_c=0.
  - Tag, target and counter arrays are not reset.
- Entry contents: valid(1), tag(32-IDX_BIT-2), hedef(32), sayac(2), atlama(1).
- Lookup (latency 1):
  - When getir_gecerli_g=1 and bosalt_g=0, the next edge registers:
    - ongoru_gecerli_c=1;
    - hit = valid && tag match;
    - ongoru_atla_c = hit && (atlama || sayac[1]);
    - ongoru_ps_c = ongoru_atla_c ? hedef : getir_ps_g+4 (32-bit wrap, carry dropped).
  - Otherwise ongoru_gecerli_c=0 next cycle; ongoru_atla_c and ongoru_ps_c hold their values.
  - bosalt_g=1 forces ongoru_gecerli_c=0 next cycle, regardless of getir_gecerli_g.
- Update (written at the edge where guncelle_gecerli_g=1):
  - Hit, conditional: sayac increments on taken, saturating at 2'b11; decrements on not-taken, saturating at 2'b00. hedef is written only when taken.
  - Hit, unconditional: hedef is always written; sayac=2'b11; atlama=1.
  - Miss, taken: allocate, overwriting any previous occupant. valid=1, tag and hedef are written, atlama=guncelle_atlama_g. sayac=2'b11 if unconditional, else 2'b10 (weakly taken).
  - Miss, not-taken: no allocation and no state change.
- Simultaneous lookup and update to the same index in one cycle:
  - The lookup sees pre-update contents (read-before-write).
  - The update always completes.
- Lookup and update in one cycle with rstn_g=0: reset wins; valid bits are cleared and the update is discarded.
- Reset mid-operation drops any in-flight prediction: ongoru_gecerli_c=0 on the following cycle.
- Misaligned PCs: ps[1:0] is ignored for both index and tag.
- No handshake back-pressure: one lookup and one update can be accepted every cycle.

Test Plan:
1. Reset, then lookup 0x0000_0100 → next cycle: ongoru_gecerli_c=1, ongoru_atla_c=0, ongoru_ps_c=0x0000_0104.
2. Taken Bxx update (ps=0x100, hedef=0x80), then lookup 0x100 → atla=1, ps_c=0x80. Then two not-taken updates, then lookup → atla=0, ps_c=0x104 (counter 10→01→00).
3. JAL update (ps=0x200, atlama=1, hedef=0x400), then 3 not-taken conditional-style updates with guncelle_atlama_g=1 → lookup of 0x200 still returns 0x400, atla=1.
4. Aliasing with GIRDI_SAYISI=16: taken update at 0x100, then taken update at 0x140 (same index, different tag) → lookup 0x100 returns atla=0, ps_c=0x104; lookup 0x140 hits.
5. Same-cycle lookup and allocating update of 0x300 → that prediction is not-taken (0x304); lookup in the next cycle returns the new target.
6. Lookup 0x100 with bosalt_g=1 → ongoru_gecerli_c=0 next cycle. Separately, assert rstn_g=0 after training → all lookups miss; lookup 0xFFFF_FFFC returns 0x0000_0000.

Source files
------------

// File: rtl/dallanma_ongorucu.sv
// Fetch-side branch predictor: direct-mapped BTB with a 2-bit saturating
// counter per entry. Lookups return one cycle after the request. Execute
// trains the table with resolved JAL/JALR/Bxx outcomes and targets.
module dallanma_ongorucu #(
  parameter int GIRDI_SAYISI = 16,
  parameter int IDX_BIT      = $clog2(GIRDI_SAYISI)
) (
  input  logic        clk_g,
  input  logic        rstn_g,
  input  logic        getir_gecerli_g,
  input  logic [31:0] getir_ps_g,
  input  logic        bosalt_g,
  output logic        ongoru_gecerli_c,
  output logic        ongoru_atla_c,
  output logic [31:0] ongoru_ps_c,
  input  logic        guncelle_gecerli_g,
  input  logic [31:0] guncelle_ps_g,
  input  logic        guncelle_atladi_g,
  input  logic [31:0] guncelle_hedef_g,
  input  logic        guncelle_atlama_g
);

  localparam int TAG_BIT = 32 - IDX_BIT - 2;

  logic [GIRDI_SAYISI-1:0] valid;
  logic [GIRDI_SAYISI-1:0] atlama_mem;
  logic [TAG_BIT-1:0]      tag_mem   [GIRDI_SAYISI];
  logic [31:0]             hedef_mem [GIRDI_SAYISI];
  logic [1:0]              sayac_mem [GIRDI_SAYISI];

  logic [IDX_BIT-1:0] getir_idx;
  logic [TAG_BIT-1:0] getir_tag;
  logic               getir_hit;
  logic               getir_atla;
  logic [31:0]        getir_sonraki;

  logic [IDX_BIT-1:0] guncelle_idx;
  logic [TAG_BIT-1:0] guncelle_tag;
  logic               guncelle_hit;
  logic [1:0]         guncelle_sayac;

  // The two low PC bits never take part in index or tag.
  logic unused_bits;
  assign unused_bits = ^{getir_ps_g[1:0], guncelle_ps_g[1:0]};

  assign getir_idx     = getir_ps_g[IDX_BIT+1:2];
  assign getir_tag     = getir_ps_g[31:IDX_BIT+2];
  assign getir_hit     = valid[getir_idx] && (tag_mem[getir_idx] == getir_tag);
  assign getir_atla    = getir_hit && (atlama_mem[getir_idx] || sayac_mem[getir_idx][1]);
  assign getir_sonraki = getir_ps_g + 32'd4;

  assign guncelle_idx   = guncelle_ps_g[IDX_BIT+1:2];
  assign guncelle_tag   = guncelle_ps_g[31:IDX_BIT+2];
  assign guncelle_hit   = valid[guncelle_idx] && (tag_mem[guncelle_idx] == guncelle_tag);
  assign guncelle_sayac = sayac_mem[guncelle_idx];

  // Registered prediction and entry valid bits; reset wipes both and drops any update.
  always_ff @(posedge clk_g) begin
    if (!rstn_g) begin
      valid            <= '0;
      ongoru_gecerli_c <= 1'b0;
      ongoru_atla_c    <= 1'b0;
      ongoru_ps_c      <= 32'd0;
    end else begin
      if (getir_gecerli_g && !bosalt_g) begin
        ongoru_gecerli_c <= 1'b1;
        ongoru_atla_c    <= getir_atla;
        ongoru_ps_c      <= getir_atla ? hedef_mem[getir_idx] : getir_sonraki;
      end else begin
        ongoru_gecerli_c <= 1'b0;
      end
      if (guncelle_gecerli_g && !guncelle_hit && guncelle_atladi_g) begin
        valid[guncelle_idx] <= 1'b1;
      end
    end
  end

  // Entry payload training: counter saturation, target refresh and allocation on taken misses.
  always_ff @(posedge clk_g) begin
    if (rstn_g && guncelle_gecerli_g) begin
      if (guncelle_hit) begin
        if (guncelle_atlama_g) begin
          hedef_mem[guncelle_idx]  <= guncelle_hedef_g;
          sayac_mem[guncelle_idx]  <= 2'b11;
          atlama_mem[guncelle_idx] <= 1'b1;
        end else if (guncelle_atladi_g) begin
          hedef_mem[guncelle_idx] <= guncelle_hedef_g;
          if (guncelle_sayac != 2'b11) begin
            sayac_mem[guncelle_idx] <= guncelle_sayac + 2'b01;
          end
        end else if (guncelle_sayac != 2'b00) begin
          sayac_mem[guncelle_idx] <= guncelle_sayac - 2'b01;
        end
      end else if (guncelle_atladi_g) begin
        tag_mem[guncelle_idx]    <= guncelle_tag;
        hedef_mem[guncelle_idx]  <= guncelle_hedef_g;
        atlama_mem[guncelle_idx] <= guncelle_atlama_g;
        sayac_mem[guncelle_idx]  <= guncelle_atlama_g ? 2'b11 : 2'b10;
      end
    end
  end

endmodule

// File: tb/tb_dallanma_ongorucu.sv
// Directed table-driven bench for the fetch-side branch predictor.
module tb_dallanma_ongorucu;

  logic        clk_g = 1'b0;
  logic        rstn_g;
  logic        getir_gecerli_g;
  logic [31:0] getir_ps_g;
  logic        bosalt_g;
  logic        ongoru_gecerli_c;
  logic        ongoru_atla_c;
  logic [31:0] ongoru_ps_c;
  logic        guncelle_gecerli_g;
  logic [31:0] guncelle_ps_g;
  logic        guncelle_atladi_g;
  logic [31:0] guncelle_hedef_g;
  logic        guncelle_atlama_g;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rstn;
    logic        gv;
    logic [31:0] gps;
    logic        bos;
    logic        uv;
    logic [31:0] ups;
    logic        uat;
    logic [31:0] uhed;
    logic        ujmp;
    logic        full;
    logic        eg;
    logic        ea;
    logic [31:0] eps;
  } vec_t;

  vec_t table_q[$];

  dallanma_ongorucu #(.GIRDI_SAYISI(16)) dut (
    .clk_g              (clk_g),
    .rstn_g             (rstn_g),
    .getir_gecerli_g    (getir_gecerli_g),
    .getir_ps_g         (getir_ps_g),
    .bosalt_g           (bosalt_g),
    .ongoru_gecerli_c   (ongoru_gecerli_c),
    .ongoru_atla_c      (ongoru_atla_c),
    .ongoru_ps_c        (ongoru_ps_c),
    .guncelle_gecerli_g (guncelle_gecerli_g),
    .guncelle_ps_g      (guncelle_ps_g),
    .guncelle_atladi_g  (guncelle_atladi_g),
    .guncelle_hedef_g   (guncelle_hedef_g),
    .guncelle_atlama_g  (guncelle_atlama_g)
  );

  // Free-running clock, 10 ns period.
  always #5 clk_g = ~clk_g;

  function automatic vec_t idle();
    vec_t v;
    v.rstn = 1'b1; v.gv = 1'b0; v.gps = 32'd0; v.bos = 1'b0;
    v.uv = 1'b0; v.ups = 32'd0; v.uat = 1'b0; v.uhed = 32'd0; v.ujmp = 1'b0;
    v.full = 1'b0; v.eg = 1'b0; v.ea = 1'b0; v.eps = 32'd0;
    return v;
  endfunction

  function automatic vec_t lk(input logic [31:0] ps, input logic ea, input logic [31:0] eps);
    vec_t v;
    v = idle();
    v.gv = 1'b1; v.gps = ps;
    v.full = 1'b1; v.eg = 1'b1; v.ea = ea; v.eps = eps;
    return v;
  endfunction

  function automatic vec_t up(input logic [31:0] ps, input logic at, input logic [31:0] hed,
                              input logic jmp);
    vec_t v;
    v = idle();
    v.uv = 1'b1; v.ups = ps; v.uat = at; v.uhed = hed; v.ujmp = jmp;
    return v;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive one vector just after an edge, let the next edge register it, then compare.
  task automatic apply_stimulus(input vec_t v, input string tag);
    rstn_g             = v.rstn;
    getir_gecerli_g    = v.gv;
    getir_ps_g         = v.gps;
    bosalt_g           = v.bos;
    guncelle_gecerli_g = v.uv;
    guncelle_ps_g      = v.ups;
    guncelle_atladi_g  = v.uat;
    guncelle_hedef_g   = v.uhed;
    guncelle_atlama_g  = v.ujmp;
    @(posedge clk_g);
    #1;
    check_output({tag, " gecerli"}, {31'd0, ongoru_gecerli_c}, {31'd0, v.eg});
    if (v.full) begin
      check_output({tag, " atla"}, {31'd0, ongoru_atla_c}, {31'd0, v.ea});
      check_output({tag, " ps"}, ongoru_ps_c, v.eps);
    end
  endtask

  initial begin
    vec_t v;

    // Reset state: all outputs zero.
    v = idle();
    v.rstn = 1'b0; v.full = 1'b1;
    apply_stimulus(v, "reset0");
    apply_stimulus(v, "reset1");

    // Miss after reset, then conditional training with saturation checks.
    table_q.push_back(lk(32'h100, 1'b0, 32'h104));
    table_q.push_back(up(32'h100, 1'b1, 32'h80, 1'b0));
    table_q.push_back(lk(32'h100, 1'b1, 32'h80));
    table_q.push_back(up(32'h100, 1'b1, 32'h80, 1'b0));
    table_q.push_back(up(32'h100, 1'b1, 32'h80, 1'b0));
    table_q.push_back(up(32'h100, 1'b0, 32'h999, 1'b0));
    table_q.push_back(lk(32'h100, 1'b1, 32'h80));
    table_q.push_back(up(32'h100, 1'b0, 32'h999, 1'b0));
    table_q.push_back(lk(32'h100, 1'b0, 32'h104));
    table_q.push_back(up(32'h100, 1'b0, 32'h999, 1'b0));
    table_q.push_back(up(32'h100, 1'b0, 32'h999, 1'b0));
    table_q.push_back(up(32'h100, 1'b1, 32'h80, 1'b0));
    table_q.push_back(up(32'h100, 1'b1, 32'h80, 1'b0));
    table_q.push_back(lk(32'h100, 1'b1, 32'h80));
    // Unconditional entry stays taken.
    table_q.push_back(up(32'h200, 1'b1, 32'h400, 1'b1));
    table_q.push_back(up(32'h200, 1'b0, 32'h400, 1'b1));
    table_q.push_back(up(32'h200, 1'b0, 32'h400, 1'b1));
    table_q.push_back(up(32'h200, 1'b0, 32'h400, 1'b1));
    table_q.push_back(lk(32'h200, 1'b1, 32'h400));
    // Aliasing, misaligned lookup, not-taken miss, other index.
    table_q.push_back(up(32'h100, 1'b1, 32'h500, 1'b0));
    table_q.push_back(up(32'h140, 1'b1, 32'h600, 1'b0));
    table_q.push_back(lk(32'h100, 1'b0, 32'h104));
    table_q.push_back(lk(32'h140, 1'b1, 32'h600));
    table_q.push_back(lk(32'h142, 1'b1, 32'h600));
    table_q.push_back(up(32'h180, 1'b0, 32'h999, 1'b0));
    table_q.push_back(lk(32'h140, 1'b1, 32'h600));
    table_q.push_back(lk(32'h144, 1'b0, 32'h148));
    // Same-cycle lookup and allocating update: read-before-write.
    v = lk(32'h300, 1'b0, 32'h304);
    v.uv = 1'b1; v.ups = 32'h300; v.uat = 1'b1; v.uhed = 32'h700; v.ujmp = 1'b0;
    table_q.push_back(v);
    table_q.push_back(lk(32'h300, 1'b1, 32'h700));
    // Flush kills the prediction; atla/ps hold.
    v = lk(32'h300, 1'b1, 32'h700);
    v.bos = 1'b1; v.eg = 1'b0;
    table_q.push_back(v);
    v = idle();
    v.full = 1'b1; v.ea = 1'b1; v.eps = 32'h700;
    table_q.push_back(v);
    table_q.push_back(lk(32'h140, 1'b0, 32'h144));
    // Reset during lookup and update: reset wins.
    v = lk(32'h300, 1'b0, 32'h0);
    v.rstn = 1'b0; v.eg = 1'b0;
    v.uv = 1'b1; v.ups = 32'h340; v.uat = 1'b1; v.uhed = 32'hA00; v.ujmp = 1'b1;
    table_q.push_back(v);
    table_q.push_back(lk(32'h300, 1'b0, 32'h304));
    table_q.push_back(lk(32'hFFFF_FFFC, 1'b0, 32'h0));
    table_q.push_back(lk(32'h340, 1'b0, 32'h344));

    foreach (table_q[i]) begin
      apply_stimulus(table_q[i], $sformatf("vec%0d", i));
    end

    // Back-to-back lookups overlapping training of the same entry.
    v = lk(32'h404, 1'b0, 32'h408);
    v.uv = 1'b1; v.ups = 32'h404; v.uat = 1'b1; v.uhed = 32'h800; v.ujmp = 1'b0;
    apply_stimulus(v, "seq_alloc");
    v = lk(32'h404, 1'b1, 32'h800);
    v.uv = 1'b1; v.ups = 32'h404; v.uat = 1'b0; v.uhed = 32'h0; v.ujmp = 1'b0;
    apply_stimulus(v, "seq_weak");
    apply_stimulus(lk(32'h404, 1'b0, 32'h408), "seq_after");

    // Reset mid-stream drops an in-flight lookup.
    apply_stimulus(lk(32'h404, 1'b0, 32'h408), "seq_pre_reset");
    v = lk(32'h404, 1'b0, 32'h0);
    v.rstn = 1'b0; v.eg = 1'b0;
    apply_stimulus(v, "seq_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
